// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Grants the single RAM port to either the instruction cache or the data
// cache. The data cache has priority, but it is never granted twice in a row
// while an instruction fill is pending. Each grant is bounded by a timeout;
// a timed-out grant spends one cycle in RECOVER and is then re-arbitrated.
//
// Ports:
//   CLK, nRST          clock, asynchronous active-low reset
//   iREN, iaddr        icache fill request / word address
//   iwait, iload       icache handshake (low on completion) / fill data
//   dREN, dWEN         dcache read / write request (write wins)
//   daddr, dstore      dcache word address / write data
//   dwait, dload       dcache handshake (low on completion) / read data
//   ramREN, ramWEN     RAM strobes
//   ramaddr, ramstore  RAM address / write data
//   ramload, ramstate  RAM read data / status (FREE, BUSY, ACCESS, ERROR)
//   timeouts           saturating count of timed-out grants
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int TIMEOUT = 64,
  parameter int CW      = 7
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic [7:0]  timeouts
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_IGNT    = 2'd1;
  localparam logic [1:0] S_DGNT    = 2'd2;
  localparam logic [1:0] S_RECOVER = 2'd3;

  localparam logic [1:0] RAM_ACCESS = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          last_d_q, last_d_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    timeouts_q, timeouts_d;

  logic d_req;
  logic access;
  logic grant;
  logic req_held;

  // Data cache first, unless it was served last and a fill is waiting.
  function automatic logic [1:0] arbitrate(input logic d, input logic i, input logic ld);
    if (d && !(ld && i)) return S_DGNT;
    else if (i)          return S_IGNT;
    else                 return S_IDLE;
  endfunction

  assign d_req    = dREN | dWEN;
  assign access   = (ramstate == RAM_ACCESS);
  assign grant    = (state_q == S_IGNT) || (state_q == S_DGNT);
  assign req_held = (state_q == S_IGNT) ? iREN : d_req;

  assign iload    = ramload;
  assign dload    = ramload;
  assign timeouts = timeouts_q;

  // RAM port and handshakes. Strobes are gated by the live request so a
  // withdrawn request drops the strobe in the same cycle.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    case (state_q)
      S_IGNT: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        iwait   = !(iREN && access);
      end
      S_DGNT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        dwait    = !(d_req && access);
      end
      default: ;
    endcase
  end

  // Next-state logic. ERROR is deliberately handled like BUSY: only the
  // timeout path leaves a grant that never sees ACCESS.
  always_comb begin
    state_d    = state_q;
    last_d_d   = last_d_q;
    cnt_d      = cnt_q;
    timeouts_d = timeouts_q;
    if (!grant) begin
      state_d = arbitrate(d_req, iREN, last_d_q);
      cnt_d   = '0;
    end else if (!req_held) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (access) begin
      // Arbitrate with the updated flag so back-to-back grants alternate.
      last_d_d = (state_q == S_DGNT);
      state_d  = arbitrate(d_req, iREN, last_d_d);
      cnt_d    = '0;
    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
      state_d = S_RECOVER;
      cnt_d   = '0;
      if (timeouts_q != 8'hFF) timeouts_d = timeouts_q + 8'd1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= S_IDLE;
      last_d_q   <= 1'b0;
      cnt_q      <= '0;
      timeouts_q <= '0;
    end else begin
      state_q    <= state_d;
      last_d_q   <= last_d_d;
      cnt_q      <= cnt_d;
      timeouts_q <= timeouts_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int TO = 4;

  logic        CLK;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic [7:0]  timeouts;

  mem_arbiter #(.TIMEOUT(TO), .CW(3)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .timeouts(timeouts)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        w;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t        iq[$];
  txn_t        dq[$];
  logic [31:0] ref_mem [0:255];
  logic [31:0] mem     [0:255];
  logic        ovr_en;
  logic [31:0] ovr_val;
  logic        mon_en;
  int          mon_to;
  int          exp_to;
  int          checks;
  int          errors;

  function automatic logic [31:0] init_val(input int k);
    return (32'(k) * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  // RAM model: read data is the addressed word; writes land on ACCESS.
  assign ramload = ovr_en ? ovr_val : mem[ramaddr[7:0]];

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = init_val(k);
    forever begin
      @(negedge CLK);
      if (ramWEN && ramstate == 2'd2) mem[ramaddr[7:0]] = ramstore;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic smp();
    @(negedge CLK);
  endtask

  // Scoreboard monitor: pops an expected response whenever a wait goes low
  // and checks the arbitration rules at the transaction level.
  task automatic monitor();
    txn_t t;
    int   pend = 0;          // 1: I must be served next, 2: D must be served next
    int   who;
    int   run = 0;           // consecutive strobed cycles without ACCESS
    bit   exp_recover = 0;
    bit   exp_strobe = 0;
    forever begin
      @(negedge CLK);
      if (mon_en) begin
        check("excl_strobes", 32'(ramREN & ramWEN), 0);
        if (exp_recover) begin
          check("recover_strobes", {30'd0, ramREN, ramWEN}, 0);
          check("recover_waits", {30'd0, iwait, dwait}, 3);
          exp_recover = 0;
        end
        if (exp_strobe) begin
          check("no_bubble", 32'(ramREN | ramWEN), 1);
          exp_strobe = 0;
        end
        if (!iwait) begin
          who = 1;
          check("one_wait_low", 32'(dwait), 1);
          if (pend != 0) check("fair_order", who, pend);
          if (iq.size() == 0) begin
            check("i_unexpected_done", 32'(iq.size()), 1);
          end else begin
            t = iq.pop_front();
            check("i_ren", 32'(ramREN), 1);
            check("i_addr", ramaddr, t.addr);
            check("i_load", iload, t.data);
            $display("txn I rd addr=%08h data=%08h", t.addr, iload);
          end
          pend = (dREN | dWEN) ? 2 : 0;
          exp_strobe = (pend != 0);
        end
        if (!dwait) begin
          who = 2;
          if (pend != 0) check("fair_order", who, pend);
          if (dq.size() == 0) begin
            check("d_unexpected_done", 32'(dq.size()), 1);
          end else begin
            t = dq.pop_front();
            check("d_addr", ramaddr, t.addr);
            if (t.w) begin
              check("d_wen", {30'd0, ramWEN, ramREN}, 2);
              check("d_store", ramstore, t.data);
              $display("txn D wr addr=%08h data=%08h", t.addr, ramstore);
            end else begin
              check("d_ren", {30'd0, ramWEN, ramREN}, 1);
              check("d_load", dload, t.data);
              $display("txn D rd addr=%08h data=%08h", t.addr, dload);
            end
          end
          pend = iREN ? 1 : 0;
          exp_strobe = (pend != 0);
        end
        if ((ramREN | ramWEN) && ramstate != 2'd2) begin
          run++;
          if (run == TO) begin
            run = 0;
            exp_recover = 1;
            if (mon_to < 255) mon_to++;
          end
        end else begin
          run = 0;
        end
      end
    end
  endtask

  // One cycle of randomized master and RAM-status stimulus.
  task automatic drive_step(input bit issue);
    logic iw, dw;
    int   r;
    txn_t t;
    @(negedge CLK);
    iw = iwait;
    dw = dwait;
    @(posedge CLK);
    #1;
    r = int'($urandom_range(9, 0));
    ramstate = (r < 6) ? 2'd2 : (r < 8) ? 2'd1 : (r < 9) ? 2'd0 : 2'd3;
    if (iREN && !iw) iREN = 1'b0;
    if ((dREN || dWEN) && !dw) begin
      dREN = 1'b0;
      dWEN = 1'b0;
    end
    if (issue && !iREN && $urandom_range(1, 0) == 1) begin
      iaddr  = 32'($urandom_range(127, 0));
      iREN   = 1'b1;
      t.w    = 1'b0;
      t.addr = iaddr;
      t.data = ref_mem[iaddr[7:0]];
      iq.push_back(t);
    end
    if (issue && !dREN && !dWEN && $urandom_range(1, 0) == 1) begin
      daddr  = 32'd128 + 32'($urandom_range(127, 0));
      t.addr = daddr;
      if ($urandom_range(1, 0) == 1) begin
        dstore = $urandom;
        dWEN   = 1'b1;
        dREN   = 1'($urandom_range(1, 0));
        t.w    = 1'b1;
        t.data = dstore;
        ref_mem[daddr[7:0]] = dstore;
      end else begin
        dREN   = 1'b1;
        dWEN   = 1'b0;
        t.w    = 1'b0;
        t.data = ref_mem[daddr[7:0]];
      end
      dq.push_back(t);
    end
  endtask

  initial begin
    int guard;
    checks  = 0;
    errors  = 0;
    mon_to  = 0;
    mon_en  = 1'b0;
    ovr_en  = 1'b0;
    ovr_val = '0;
    nRST    = 1'b0;
    iREN    = 1'b1;
    dREN    = 1'b1;
    dWEN    = 1'b1;
    iaddr   = 32'h44;
    daddr   = 32'h144;
    dstore  = 32'h12345678;
    ramstate = 2'd2;
    for (int k = 0; k < 256; k++) ref_mem[k] = init_val(k);
    fork
      monitor();
    join_none

    // Reset state with requests asserted.
    repeat (3) @(posedge CLK);
    smp();
    check("rst_ramREN", 32'(ramREN), 0);
    check("rst_ramWEN", 32'(ramWEN), 0);
    check("rst_ramaddr", ramaddr, 0);
    check("rst_ramstore", ramstore, 0);
    check("rst_iwait", 32'(iwait), 1);
    check("rst_dwait", 32'(dwait), 1);
    check("rst_timeouts", 32'(timeouts), 0);
    cyc();
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    nRST = 1'b1;
    cyc(); cyc();

    // Randomized traffic against the scoreboard.
    mon_en = 1'b1;
    for (int n = 0; n < 2500; n++) drive_step(1'b1);
    guard = 0;
    while ((iREN || dREN || dWEN) && guard < 1000) begin
      drive_step(1'b0);
      guard++;
    end
    check("drain_done", 32'(iREN | dREN | dWEN), 0);
    ramstate = 2'd1;
    repeat (3) cyc();
    smp();
    check("iq_empty", 32'(iq.size()), 0);
    check("dq_empty", 32'(dq.size()), 0);
    check("rand_timeouts", 32'(timeouts), 32'(mon_to));
    exp_to = mon_to;
    mon_en = 1'b0;

    // Single I fill: two BUSY cycles then ACCESS.
    ovr_en = 1'b1; ovr_val = 32'h2401000A;
    cyc(); iREN = 1'b1; iaddr = 32'h40; ramstate = 2'd1;
    smp(); check("fill_idle_ren", 32'(ramREN), 0);
    cyc(); smp();
    check("fill_c1_ren", 32'(ramREN), 1);
    check("fill_c1_addr", ramaddr, 32'h40);
    check("fill_c1_iwait", 32'(iwait), 1);
    cyc(); smp();
    check("fill_c2_ren", 32'(ramREN), 1);
    check("fill_c2_iwait", 32'(iwait), 1);
    cyc(); ramstate = 2'd2; smp();
    check("fill_c3_ren", 32'(ramREN), 1);
    check("fill_c3_iwait", 32'(iwait), 0);
    check("fill_c3_iload", iload, 32'h2401000A);
    cyc(); iREN = 1'b0; smp();
    check("fill_after_ren", 32'(ramREN), 0);
    ovr_en = 1'b0;
    $display("txn directed fill done");

    // Contention: D first, then strict alternation with no idle cycles.
    cyc(); iREN = 1'b1; dREN = 1'b1; iaddr = 32'h20; daddr = 32'h120; ramstate = 2'd2;
    smp(); check("cont_idle", 32'(ramREN | ramWEN), 0);
    for (int k = 0; k < 6; k++) begin
      cyc(); smp();
      check("cont_dwait", 32'(dwait), (k % 2 == 0) ? 0 : 1);
      check("cont_iwait", 32'(iwait), (k % 2 == 0) ? 1 : 0);
      check("cont_ren", 32'(ramREN), 1);
    end
    cyc(); iREN = 1'b0; dREN = 1'b0; smp();
    check("cont_end", 32'(ramREN | ramWEN), 0);
    $display("txn directed contention done");

    // Withdrawal of a D grant while BUSY, with a fill pending.
    cyc(); dREN = 1'b1; daddr = 32'h130; iREN = 1'b1; iaddr = 32'h30; ramstate = 2'd1;
    smp(); check("wd_idle", 32'(ramREN), 0);
    cyc(); smp();
    check("wd_dgnt_ren", 32'(ramREN), 1);
    check("wd_dgnt_addr", ramaddr, 32'h130);
    cyc(); dREN = 1'b0; smp();
    check("wd_drop_ren", 32'(ramREN), 0);
    check("wd_drop_dwait", 32'(dwait), 1);
    cyc(); smp();
    check("wd_gap_ren", 32'(ramREN), 0);
    cyc(); ramstate = 2'd2; smp();
    check("wd_igrant_ren", 32'(ramREN), 1);
    check("wd_igrant_addr", ramaddr, 32'h30);
    check("wd_igrant_iwait", 32'(iwait), 0);
    cyc(); iREN = 1'b0; smp();
    $display("txn directed withdrawal done");

    // Write wins over read.
    cyc(); dREN = 1'b1; dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEADBEEF; ramstate = 2'd2;
    smp();
    cyc(); smp();
    check("wp_wen", 32'(ramWEN), 1);
    check("wp_ren", 32'(ramREN), 0);
    check("wp_store", ramstore, 32'hDEADBEEF);
    check("wp_addr", ramaddr, 32'h100);
    check("wp_dwait", 32'(dwait), 0);
    cyc(); dREN = 1'b0; dWEN = 1'b0; smp();
    $display("txn directed write done");

    // Timeout with RAM stuck BUSY, then saturation of the counter.
    cyc(); iREN = 1'b1; iaddr = 32'h10; ramstate = 2'd1;
    smp(); check("to_idle", 32'(ramREN), 0);
    for (int k = 0; k < TO; k++) begin
      cyc(); smp();
      check("to_grant_ren", 32'(ramREN), 1);
      check("to_grant_iwait", 32'(iwait), 1);
    end
    if (exp_to < 255) exp_to++;
    cyc(); smp();
    check("to_recover_ren", 32'(ramREN), 0);
    check("to_recover_iwait", 32'(iwait), 1);
    check("to_count", 32'(timeouts), 32'(exp_to));
    cyc(); smp();
    check("to_regrant", 32'(ramREN), 1);
    repeat ((TO + 1) * 260) cyc();
    smp();
    check("to_saturated", 32'(timeouts), 255);
    $display("txn directed timeout done");

    // Asynchronous reset in the middle of a D write grant.
    cyc(); iREN = 1'b0;
    cyc(); dWEN = 1'b1; daddr = 32'h180; dstore = 32'hCAFEF00D; ramstate = 2'd1;
    cyc(); smp();
    check("rm_wen_before", 32'(ramWEN), 1);
    @(posedge CLK);
    #2 nRST = 1'b0;
    #1;
    check("rm_wen", 32'(ramWEN), 0);
    check("rm_ren", 32'(ramREN), 0);
    check("rm_dwait", 32'(dwait), 1);
    check("rm_timeouts", 32'(timeouts), 0);
    cyc(); dWEN = 1'b0; nRST = 1'b1;
    cyc();
    $display("txn directed reset done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
